// File: rtl/fsm_code_lock_if.sv
// Key/status bundle between the key debouncers, the code lock and the LED/actuator drivers.
interface fsm_code_lock_if #(
  parameter int N_KEYS   = 4,
  parameter int CODE_LEN = 4,
  parameter int MAX_FAIL = 3
);
  localparam int FW = $clog2(MAX_FAIL+1);

  logic [N_KEYS-1:0]   key_in;
  logic                unlocked;
  logic                error;
  logic                lockout;
  logic [CODE_LEN-1:0] progress;
  logic [FW-1:0]       fail_cnt;
  logic [2:0]          state_o;

  modport master (output key_in, input unlocked, error, lockout, progress, fail_cnt, state_o);
  modport slave  (input key_in, output unlocked, error, lockout, progress, fail_cnt, state_o);
endinterface

// File: rtl/fsm_code_lock.sv
// Parametrised key-sequence lock: edge-detected presses checked against CODE,
// with inter-key timeout, consecutive-failure counter and timed lockout.
module fsm_code_lock #(
  parameter int N_KEYS      = 4,
  parameter int KEY_W       = $clog2(N_KEYS),
  parameter int CODE_LEN    = 4,
  parameter logic [CODE_LEN*KEY_W-1:0] CODE = 8'hE4,
  parameter int CLR_KEY     = N_KEYS-1,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 250_000_000
) (
  input  logic clk,
  input  logic rstn,
  fsm_code_lock_if.slave bus
);
  localparam int TMAX  = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC;
  localparam int TW    = $clog2(TMAX+1);
  localparam int IDX_W = $clog2(CODE_LEN+1);
  localparam int FW    = $clog2(MAX_FAIL+1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_OK    = 3'd2,
    S_ERROR = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  state_t              state, nxt_state;
  logic [IDX_W-1:0]    idx, nxt_idx;
  logic [TW-1:0]       timer, nxt_timer;
  logic [FW-1:0]       fail_cnt, nxt_fail;
  logic [N_KEYS-1:0]   key_d, press;
  logic [KEY_W-1:0]    k;
  logic                any_press, valid;
  logic [CODE_LEN-1:0] therm;
  logic                unlocked_q, error_q, lockout_q;
  logic [CODE_LEN-1:0] progress_q;

  function automatic logic [KEY_W-1:0] code_at(input logic [IDX_W-1:0] i);
    return CODE[int'(i)*KEY_W +: KEY_W];
  endfunction

  assign press     = bus.key_in & ~key_d;
  assign any_press = |press;
  assign valid     = $onehot(press);

  always_comb begin
    k = '0;
    for (int i = 0; i < N_KEYS; i++)
      if (press[i]) k = KEY_W'(i);
  end

  always_comb begin
    logic do_fail;
    do_fail   = 1'b0;
    nxt_state = state;
    nxt_idx   = idx;
    nxt_timer = timer;
    nxt_fail  = fail_cnt;
    case (state)
      S_IDLE: begin
        if (valid && k == code_at('0)) begin
          nxt_idx   = IDX_W'(1);
          nxt_timer = '0;
          nxt_state = (CODE_LEN == 1) ? S_OK : S_ENTRY;
        end else if (any_press) begin
          do_fail = 1'b1;
        end
      end
      S_ENTRY: begin
        // a press on the timeout cycle takes priority over the timeout
        if (valid && k == code_at(idx)) begin
          nxt_idx   = idx + IDX_W'(1);
          nxt_timer = '0;
          if (nxt_idx == IDX_W'(CODE_LEN)) nxt_state = S_OK;
        end else if (any_press) begin
          do_fail = 1'b1;
        end else if (timer == TW'(TIMEOUT_CYC-1)) begin
          do_fail = 1'b1;
        end else begin
          nxt_timer = timer + TW'(1);
        end
      end
      S_OK: begin
        if (any_press) begin
          nxt_state = S_IDLE;
          nxt_idx   = '0;
        end
      end
      S_ERROR: begin
        if (valid && k == KEY_W'(CLR_KEY)) nxt_state = S_IDLE;
      end
      S_LOCK: begin
        if (timer == TW'(LOCKOUT_CYC-1)) begin
          nxt_state = S_IDLE;
          nxt_timer = '0;
          nxt_fail  = '0;
        end else begin
          nxt_timer = timer + TW'(1);
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_idx   = '0;
        nxt_timer = '0;
      end
    endcase

    if (do_fail) begin
      nxt_idx   = '0;
      nxt_timer = '0;
      nxt_fail  = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + FW'(1);
      nxt_state = (nxt_fail == FW'(MAX_FAIL)) ? S_LOCK : S_ERROR;
    end
    if (nxt_state == S_OK) nxt_fail = '0;
  end

  always_comb begin
    therm = '0;
    for (int j = 0; j < CODE_LEN; j++)
      therm[j] = (int'(nxt_idx) > j);
  end

  // outputs are decoded from the next state so they flip on the same edge as state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      idx        <= '0;
      timer      <= '0;
      fail_cnt   <= '0;
      key_d      <= '1;
      unlocked_q <= 1'b0;
      error_q    <= 1'b0;
      lockout_q  <= 1'b0;
      progress_q <= '0;
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      timer      <= nxt_timer;
      fail_cnt   <= nxt_fail;
      key_d      <= bus.key_in;
      unlocked_q <= (nxt_state == S_OK);
      error_q    <= (nxt_state == S_ERROR);
      lockout_q  <= (nxt_state == S_LOCK);
      progress_q <= (nxt_state == S_OK)    ? '1 :
                    (nxt_state == S_ENTRY) ? therm : '0;
    end
  end

  assign bus.unlocked = unlocked_q;
  assign bus.error    = error_q;
  assign bus.lockout  = lockout_q;
  assign bus.progress = progress_q;
  assign bus.fail_cnt = fail_cnt;
  assign bus.state_o  = state;
endmodule

// File: tb/tb_fsm_code_lock.sv
// Directed bench for fsm_code_lock: vector table for the main paths, hand sequences for timing corners.
module tb_fsm_code_lock;
  logic clk, rstn;
  int total = 0, bad = 0;

  fsm_code_lock_if #(.N_KEYS(4), .CODE_LEN(4), .MAX_FAIL(3)) bus ();

  fsm_code_lock #(.TIMEOUT_CYC(20), .LOCKOUT_CYC(30)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  typedef struct packed {
    logic [3:0]  key;
    logic [11:0] exp;  // {state, progress, fail_cnt, unlocked, error, lockout}
  } vec_t;

  vec_t tbl [35];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] ex(input logic [2:0] st, input logic [3:0] pg,
                                     input logic [1:0] fc, input logic u, e, l);
    return {st, pg, fc, u, e, l};
  endfunction

  function automatic vec_t mk(input logic [3:0] key, input logic [11:0] e);
    vec_t v;
    v.key = key;
    v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [11:0] e);
    logic [11:0] act;
    act = {bus.state_o, bus.progress, bus.fail_cnt, bus.unlocked, bus.error, bus.lockout};
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got st=%0d pg=%b fc=%0d u/e/l=%b, want st=%0d pg=%b fc=%0d u/e/l=%b",
               nm, act[11:9], act[8:5], act[4:3], act[2:0], e[11:9], e[8:5], e[4:3], e[2:0]);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.key_in = '0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic hit(input int k);
    bus.key_in = 4'(1 << k);
    tick();
    bus.key_in = '0;
  endtask

  initial begin
    rstn = 1'b0;
    bus.key_in = '0;
    tick();
    chk("reset", ex(0, 4'h0, 0, 0, 0, 0));
    tick();
    rstn = 1'b1;
    tick();
    chk("post_reset", ex(0, 4'h0, 0, 0, 0, 0));

    tbl[0]  = mk(4'h1, ex(1, 4'h1, 0, 0, 0, 0));
    tbl[1]  = mk(4'h0, ex(1, 4'h1, 0, 0, 0, 0));
    tbl[2]  = mk(4'h2, ex(1, 4'h3, 0, 0, 0, 0));
    tbl[3]  = mk(4'h0, ex(1, 4'h3, 0, 0, 0, 0));
    tbl[4]  = mk(4'h4, ex(1, 4'h7, 0, 0, 0, 0));
    tbl[5]  = mk(4'h0, ex(1, 4'h7, 0, 0, 0, 0));
    tbl[6]  = mk(4'h8, ex(2, 4'hF, 0, 1, 0, 0));
    tbl[7]  = mk(4'h0, ex(2, 4'hF, 0, 1, 0, 0));
    tbl[8]  = mk(4'h2, ex(0, 4'h0, 0, 0, 0, 0));
    tbl[9]  = mk(4'h0, ex(0, 4'h0, 0, 0, 0, 0));
    tbl[10] = mk(4'h1, ex(1, 4'h1, 0, 0, 0, 0));
    tbl[11] = mk(4'h0, ex(1, 4'h1, 0, 0, 0, 0));
    tbl[12] = mk(4'h4, ex(3, 4'h0, 1, 0, 1, 0));
    tbl[13] = mk(4'h0, ex(3, 4'h0, 1, 0, 1, 0));
    tbl[14] = mk(4'h2, ex(3, 4'h0, 1, 0, 1, 0));
    tbl[15] = mk(4'h0, ex(3, 4'h0, 1, 0, 1, 0));
    tbl[16] = mk(4'h8, ex(0, 4'h0, 1, 0, 0, 0));
    tbl[17] = mk(4'h0, ex(0, 4'h0, 1, 0, 0, 0));
    tbl[18] = mk(4'h3, ex(3, 4'h0, 2, 0, 1, 0));
    tbl[19] = mk(4'h0, ex(3, 4'h0, 2, 0, 1, 0));
    tbl[20] = mk(4'h8, ex(0, 4'h0, 2, 0, 0, 0));
    tbl[21] = mk(4'h0, ex(0, 4'h0, 2, 0, 0, 0));
    tbl[22] = mk(4'h1, ex(1, 4'h1, 2, 0, 0, 0));
    tbl[23] = mk(4'h0, ex(1, 4'h1, 2, 0, 0, 0));
    tbl[24] = mk(4'h2, ex(1, 4'h3, 2, 0, 0, 0));
    tbl[25] = mk(4'h0, ex(1, 4'h3, 2, 0, 0, 0));
    tbl[26] = mk(4'h4, ex(1, 4'h7, 2, 0, 0, 0));
    tbl[27] = mk(4'h0, ex(1, 4'h7, 2, 0, 0, 0));
    tbl[28] = mk(4'h8, ex(2, 4'hF, 0, 1, 0, 0));
    tbl[29] = mk(4'h0, ex(2, 4'hF, 0, 1, 0, 0));
    tbl[30] = mk(4'h1, ex(0, 4'h0, 0, 0, 0, 0));
    tbl[31] = mk(4'h0, ex(0, 4'h0, 0, 0, 0, 0));
    tbl[32] = mk(4'h1, ex(1, 4'h1, 0, 0, 0, 0));
    tbl[33] = mk(4'h1, ex(1, 4'h1, 0, 0, 0, 0));
    tbl[34] = mk(4'h0, ex(1, 4'h1, 0, 0, 0, 0));

    for (int i = 0; i < 35; i++) begin
      bus.key_in = tbl[i].key;
      tick();
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    bus.key_in = '0;

    // timeout: 19 idle cycles survive, the 20th fails
    do_reset();
    hit(0);
    chk("to_start", ex(1, 4'h1, 0, 0, 0, 0));
    repeat (19) tick();
    chk("to_pre", ex(1, 4'h1, 0, 0, 0, 0));
    tick();
    chk("to_fire", ex(3, 4'h0, 1, 0, 1, 0));

    // a correct press on the timeout cycle wins
    do_reset();
    hit(0);
    repeat (19) tick();
    hit(1);
    chk("to_press", ex(1, 4'h3, 0, 0, 0, 0));

    // lockout after three failures, then a timed release
    do_reset();
    hit(2); tick(); chk("lk_f1", ex(3, 4'h0, 1, 0, 1, 0));
    hit(3); tick(); chk("lk_c1", ex(0, 4'h0, 1, 0, 0, 0));
    hit(2); tick(); chk("lk_f2", ex(3, 4'h0, 2, 0, 1, 0));
    hit(3); tick();
    hit(2);
    chk("lk_enter", ex(4, 4'h0, 3, 0, 0, 1));
    for (int i = 1; i < 30; i++) begin
      bus.key_in = (i % 2 == 1) ? 4'h8 : 4'h1;
      tick();
    end
    chk("lk_hold", ex(4, 4'h0, 3, 0, 0, 1));
    bus.key_in = '0;
    tick();
    chk("lk_exit", ex(0, 4'h0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      hit(i);
      tick();
    end
    chk("lk_unlock", ex(2, 4'hF, 0, 1, 0, 0));

    // key held through reset release is not a press
    rstn = 1'b0;
    bus.key_in = 4'h1;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    tick();
    chk("held_rst", ex(0, 4'h0, 0, 0, 0, 0));
    bus.key_in = '0;
    tick();
    chk("held_rel", ex(0, 4'h0, 0, 0, 0, 0));

    // asynchronous reset while in ENTRY with idx=2
    hit(0); tick();
    hit(1);
    chk("mid_entry", ex(1, 4'h3, 0, 0, 0, 0));
    rstn = 1'b0;
    #1;
    chk("async_rst", ex(0, 4'h0, 0, 0, 0, 0));
    tick();
    chk("rst_clk", ex(0, 4'h0, 0, 0, 0, 0));
    rstn = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
